// File: rtl/req_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared slave.
interface req_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   m_req;
  logic [8*N_REQ-1:0] m_data;
  logic [N_REQ-1:0]   m_done;
  logic               m_err;
  logic               s_req;
  logic [7:0]         s_data;
  logic               s_ack;
  logic               busy;
  logic [2:0]         grant_id;

  // Arbiter side
  modport master (
    input  m_req, m_data, s_ack,
    output m_done, m_err, s_req, s_data, busy, grant_id
  );

  // Environment side (requesters and slave)
  modport slave (
    output m_req, m_data, s_ack,
    input  m_done, m_err, s_req, s_data, busy, grant_id
  );
endinterface

// File: rtl/req_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared slave,
// with a request/acknowledge handshake, ack timeout and registered outputs.
module req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  req_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam int unsigned NR   = N_REQ;
  localparam logic [7:0]  LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state_q,  state_d;
  logic [2:0]       ptr_q,    ptr_d;
  logic [7:0]       cnt_q,    cnt_d;
  logic             err_q,    err_d;
  logic [2:0]       grant_q,  grant_d;
  logic [7:0]       sdata_q,  sdata_d;
  logic             sreq_q,   sreq_d;
  logic [N_REQ-1:0] done_q,   done_d;
  logic             merr_q,   merr_d;
  logic             busy_q,   busy_d;

  logic             win_found;
  int unsigned      win_int;
  int unsigned      cand;
  logic [N_REQ-1:0] grant_onehot;

  // Round-robin search starting at the pointer (next index after last winner)
  always_comb begin
    win_found = 1'b0;
    win_int   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = (32'(ptr_q) + k) % NR;
      if (!win_found && bus.m_req[cand]) begin
        win_found = 1'b1;
        win_int   = cand;
      end
    end
  end

  // One-hot decode of the current grant for the completion pulse
  always_comb begin
    grant_onehot = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      grant_onehot[i] = (grant_q == 3'(i));
    end
  end

  // Next-state logic; m_done/m_err are set on entry to S_DONE so the
  // registered pulse coincides with the S_DONE cycle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    grant_d = grant_q;
    sdata_d = sdata_q;
    sreq_d  = sreq_q;
    done_d  = '0;
    merr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = 3'(win_int);
          sdata_d = bus.m_data[8*win_int +: 8];
          sreq_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.s_ack) begin
          sreq_d  = 1'b0;
          state_d = S_RELEASE;
        end else if (cnt_q == LAST) begin
          sreq_d  = 1'b0;
          err_d   = 1'b1;
          done_d  = grant_onehot;
          merr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RELEASE: begin
        if (!bus.s_ack) begin
          done_d  = grant_onehot;
          merr_d  = err_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        ptr_d   = 3'((32'(grant_q) + 32'd1) % NR);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= '0;
      sdata_q <= '0;
      sreq_q  <= 1'b0;
      done_q  <= '0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      sdata_q <= sdata_d;
      sreq_q  <= sreq_d;
      done_q  <= done_d;
      merr_q  <= merr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.s_req    = sreq_q;
  assign bus.s_data   = sdata_q;
  assign bus.m_done   = done_q;
  assign bus.m_err    = merr_q;
  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule

// File: doc/req_arbiter.md
REQ_ARBITER -- requirements
Module: req_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for s_ack in S_REQ (1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 m_req  input  N_REQ  SHALL carry per-requester request levels, each held until its m_done.
REQ-006 m_data  input  8*N_REQ  SHALL carry the byte for requester i on bits [8i+7:8i].
REQ-007 m_done  output  N_REQ  SHALL be a one-hot, one-cycle completion pulse to the granted requester.
REQ-008 m_err  output  1  SHALL pulse together with m_done when the transfer timed out.
REQ-009 s_req  output  1  SHALL be the request to the shared slave.
REQ-010 s_data  output  8  SHALL be the byte presented to the slave.
REQ-011 s_ack  input  1  SHALL be the acknowledge from the slave.
REQ-012 busy  output  1  SHALL be high whenever the state is not S_IDLE.
REQ-013 grant_id  output  3  SHALL hold the index of the current or most recent winner.

Function
REQ-014 The FSM SHALL have the states S_IDLE, S_REQ, S_RELEASE and S_DONE, and all outputs SHALL be registered.
REQ-015 S_IDLE: on any m_req bit high, the FSM SHALL select the winner round-robin, register grant_id, capture its m_data into s_data, set s_req=1, clear the timeout counter and go to S_REQ.
REQ-016 Round-robin: search SHALL start at (last winner + 1) mod N_REQ and wrap; after reset the search SHALL start at index 0.
REQ-017 S_REQ: s_req SHALL be held at 1 and s_data held stable; on s_ack=1 the FSM SHALL clear s_req and go to S_RELEASE.
REQ-018 S_REQ timeout: the counter SHALL increment each cycle with s_ack=0; on reaching TIMEOUT the FSM SHALL clear s_req, set an error flag and go to S_DONE.
REQ-019 If s_ack=1 arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and no error SHALL be flagged.
REQ-020 S_RELEASE: s_req SHALL be 0; the FSM SHALL stay until s_ack=0 is sampled, then go to S_DONE, so the slave is back in its wait state before any new request.
REQ-021 S_DONE: the FSM SHALL drive m_done[grant_id]=1 and m_err=error flag for exactly one cycle, clear the error flag, update the round-robin pointer and go to S_IDLE.
REQ-022 m_done and m_err SHALL be 0 in every state other than S_DONE.
REQ-023 The arbiter SHALL NOT grant the same requester again until one cycle after its m_done, even if its m_req is still high.
REQ-024 A requester that drops m_req after being granted SHALL NOT abort the transfer; the captured byte SHALL still be sent and m_done SHALL still be issued.
REQ-025 m_data and m_req changes outside S_IDLE SHALL be ignored.
REQ-026 With no requests, s_req SHALL stay 0 and s_data and grant_id SHALL hold their last values.

Reset
REQ-027 On rst=1, asynchronously: state SHALL be S_IDLE; s_req, m_done, m_err and busy SHALL be 0; s_data SHALL be 8'h00; grant_id SHALL be 0; the pointer, timeout counter and error flag SHALL be 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer, and no m_done SHALL be issued for it.
REQ-029 After rst deasserts, the first arbitration SHALL occur on the first rising edge with m_req nonzero.

Verification
REQ-030 Single request, slave model attached (2-cycle ack after request): m_req=4'b0001, m_data[7:0]=8'hA5 -> s_data=8'hA5; s_req high until s_ack seen; m_done=4'b0001 pulse on the 6th edge after grant; m_err=0.
REQ-031 All four m_req held high -> grants in order 0,1,2,3,0; exactly one m_done bit per transfer; s_data matches each requester's byte.
REQ-032 s_ack tied 0, TIMEOUT=16 -> s_req drops after 16 cycles in S_REQ; m_done[winner]=1 with m_err=1 for one cycle; next grant proceeds normally.
REQ-033 s_ack asserted on exactly the TIMEOUT cycle -> normal completion with m_err=0.
REQ-034 rst pulsed while in S_REQ -> s_req=0 and busy=0 immediately; no m_done pulse; the next request is granted to requester 0 first.
REQ-035 Requester 2 drops m_req one cycle after grant -> the transfer completes and m_done=4'b0100 is still pulsed.
